// File: rtl/imm_ctrl_pkg.sv
// Shared encodings, opcode constants and types for the decode-stage immediate controller.
package imm_ctrl_pkg;

  localparam logic [4:0] IMM_CTRL_NONE  = 5'b00000;
  localparam logic [4:0] IMM_CTRL_ITYPE = 5'b00001;
  localparam logic [4:0] IMM_CTRL_STYPE = 5'b00010;
  localparam logic [4:0] IMM_CTRL_BTYPE = 5'b00100;
  localparam logic [4:0] IMM_CTRL_UTYPE = 5'b01000;
  localparam logic [4:0] IMM_CTRL_JTYPE = 5'b10000;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam int STAT_NUM = 6;

  typedef struct packed {
    logic [4:0]  immctrl;
    logic        illegal;
    logic [11:0] iimm;
    logic [11:0] simm;
    logic [11:0] bimm;
    logic [19:0] uimm;
    logic [19:0] jimm;
  } imm_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/imm_ctrl_if.sv
// Fetch-side push, consumer-side pop and statistics readback signals of imm_ctrl.
interface imm_ctrl_if #(
  parameter int STAT_W = 32
);
  logic [31:0]       instr_i;
  logic              instr_valid_i;
  logic              instr_ready_o;
  logic              flush_i;
  logic              imm_valid_o;
  logic              imm_ready_i;
  logic [4:0]        immctrl_o;
  logic [11:0]       iimm_o;
  logic [11:0]       simm_o;
  logic [11:0]       bimm_o;
  logic [19:0]       uimm_o;
  logic [19:0]       jimm_o;
  logic              imm_illegal_o;
  logic [2:0]        stat_sel_i;
  logic [STAT_W-1:0] stat_o;

  modport master (
    output instr_i, instr_valid_i, flush_i, imm_ready_i, stat_sel_i,
    input  instr_ready_o, imm_valid_o, immctrl_o, iimm_o, simm_o, bimm_o,
           uimm_o, jimm_o, imm_illegal_o, stat_o
  );

  modport slave (
    input  instr_i, instr_valid_i, flush_i, imm_ready_i, stat_sel_i,
    output instr_ready_o, imm_valid_o, immctrl_o, iimm_o, simm_o, bimm_o,
           uimm_o, jimm_o, imm_illegal_o, stat_o
  );
endinterface

// File: rtl/imm_ctrl_decode.sv
// imm_decode: combinational opcode classification and raw immediate field slicing.
import imm_ctrl_pkg::*;

module imm_decode #(
  parameter int INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output imm_entry_t         entry
);

  always_comb begin
    entry.illegal = 1'b0;
    case (instr[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR: entry.immctrl = IMM_CTRL_ITYPE;
      OPC_STORE:                     entry.immctrl = IMM_CTRL_STYPE;
      OPC_BRANCH:                    entry.immctrl = IMM_CTRL_BTYPE;
      OPC_LUI, OPC_AUIPC:            entry.immctrl = IMM_CTRL_UTYPE;
      OPC_JAL:                       entry.immctrl = IMM_CTRL_JTYPE;
      OPC_OP, OPC_SYSTEM, OPC_FENCE: entry.immctrl = IMM_CTRL_NONE;
      default: begin
        entry.immctrl = IMM_CTRL_NONE;
        entry.illegal = 1'b1;
      end
    endcase
  end

  // Fields are sliced for every instruction; shift-immediates keep the raw iimm.
  assign entry.iimm = instr[31:20];
  assign entry.simm = {instr[31:25], instr[11:7]};
  assign entry.bimm = {instr[31], instr[7], instr[30:25], instr[11:8]};
  assign entry.uimm = instr[31:12];
  assign entry.jimm = {instr[31], instr[19:12], instr[20], instr[30:21]};

endmodule

// File: rtl/imm_ctrl.sv
// Decode-stage immediate controller: 2-entry skid buffer toward ID/EX with flush.
// Optional per-class pop counters are built when IMM_CTRL_STATS_EN is defined.
import imm_ctrl_pkg::*;

module imm_ctrl #(
  parameter int INSTR_W = 32,
  parameter int STAT_W  = 32
) (
  input  logic         clk,
  input  logic         reset,
  imm_ctrl_if.slave    bus
);

  // state    | meaning
  // ST_EMPTY | no entry buffered, outputs zero
  // ST_ONE   | head valid, skid empty
  // ST_TWO   | head and skid valid, fetch stalled

  buf_state_t state;
  imm_entry_t dec;
  imm_entry_t head;
  imm_entry_t skid;
  logic       ready_r;
  logic       push;
  logic       pop;

  imm_decode #(.INSTR_W(INSTR_W)) u_decode (
    .instr (bus.instr_i),
    .entry (dec)
  );

  assign push = bus.instr_valid_i & ready_r;
  assign pop  = (state != ST_EMPTY) & bus.imm_ready_i;

  always_ff @(posedge clk) begin
    if (reset || bus.flush_i) begin
      state   <= ST_EMPTY;
      head    <= '0;
      skid    <= '0;
      ready_r <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            head  <= dec;
            state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head <= dec;
          end else if (push) begin
            skid    <= dec;
            state   <= ST_TWO;
            ready_r <= 1'b0;
          end else if (pop) begin
            head  <= '0;
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            head    <= skid;
            skid    <= '0;
            state   <= ST_ONE;
            ready_r <= 1'b1;
          end
        end
        default: begin
          state   <= ST_EMPTY;
          head    <= '0;
          skid    <= '0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.instr_ready_o = ready_r;
  assign bus.imm_valid_o   = (state != ST_EMPTY);
  assign bus.immctrl_o     = head.immctrl;
  assign bus.imm_illegal_o = head.illegal;
  assign bus.iimm_o        = head.iimm;
  assign bus.simm_o        = head.simm;
  assign bus.bimm_o        = head.bimm;
  assign bus.uimm_o        = head.uimm;
  assign bus.jimm_o        = head.jimm;

`ifdef IMM_CTRL_STATS_EN
  logic [STAT_W-1:0]   cnt [STAT_NUM];
  logic [STAT_NUM-1:0] inc;

  // Counter order matches the one-hot immctrl bits, then illegal.
  assign inc = {head.illegal, head.immctrl} & {STAT_NUM{pop & ~bus.flush_i}};

  always_ff @(posedge clk) begin
    for (int i = 0; i < STAT_NUM; i++) begin
      if (reset) begin
        cnt[i] <= '0;
      end else if (inc[i] && (cnt[i] != {STAT_W{1'b1}})) begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    bus.stat_o = '0;
    case (bus.stat_sel_i)
      3'd0: bus.stat_o = cnt[0];
      3'd1: bus.stat_o = cnt[1];
      3'd2: bus.stat_o = cnt[2];
      3'd3: bus.stat_o = cnt[3];
      3'd4: bus.stat_o = cnt[4];
      3'd5: bus.stat_o = cnt[5];
      default: bus.stat_o = '0;
    endcase
  end
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^bus.stat_sel_i;
  assign bus.stat_o      = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_imm_ctrl.sv
// Directed self-checking bench for imm_ctrl (buffer, decode, flush, reset, stats).
`timescale 1ns/1ps
module tb_imm_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   fails;

  imm_ctrl_if #(.STAT_W(32)) bus ();

  imm_ctrl #(.INSTR_W(32), .STAT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.instr_i       = 32'h0;
    bus.instr_valid_i = 1'b0;
    bus.flush_i       = 1'b0;
    bus.imm_ready_i   = 1'b0;
    bus.stat_sel_i    = 3'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.instr_i       = 32'hFFF00093;
    bus.instr_valid_i = 1'b1;
    bus.imm_ready_i   = 1'b1;
    bus.flush_i       = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    idle_inputs();
    tick();
    checks++;
    if (bus.imm_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", bus.imm_valid_o); end
    checks++;
    if (bus.immctrl_o !== 5'b00000) begin fails++; $display("FAIL reset_immctrl: got %05b expected 00000", bus.immctrl_o); end
    checks++;
    if (bus.instr_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b expected 1", bus.instr_ready_o); end
    checks++;
    if ({bus.iimm_o, bus.simm_o, bus.bimm_o, bus.uimm_o, bus.jimm_o, bus.imm_illegal_o} !== 77'h0) begin
      fails++; $display("FAIL reset_fields: got %0h expected 0",
                        {bus.iimm_o, bus.simm_o, bus.bimm_o, bus.uimm_o, bus.jimm_o, bus.imm_illegal_o});
    end
  endtask

  task automatic test_addi();
    bus.imm_ready_i   = 1'b1;
    bus.instr_i       = 32'hFFF00093;
    bus.instr_valid_i = 1'b1;
    tick();
    bus.instr_valid_i = 1'b0;
    checks++;
    if (bus.imm_valid_o !== 1'b1) begin fails++; $display("FAIL addi_valid: got %0b expected 1", bus.imm_valid_o); end
    checks++;
    if (bus.immctrl_o !== 5'b00001) begin fails++; $display("FAIL addi_immctrl: got %05b expected 00001", bus.immctrl_o); end
    checks++;
    if (bus.iimm_o !== 12'hFFF) begin fails++; $display("FAIL addi_iimm: got %03h expected fff", bus.iimm_o); end
    checks++;
    if (bus.imm_illegal_o !== 1'b0) begin fails++; $display("FAIL addi_illegal: got %0b expected 0", bus.imm_illegal_o); end
    tick();
    checks++;
    if (bus.imm_valid_o !== 1'b0 || bus.iimm_o !== 12'h000) begin
      fails++; $display("FAIL addi_drain: got valid=%0b iimm=%03h expected valid=0 iimm=000", bus.imm_valid_o, bus.iimm_o);
    end
  endtask

  task automatic test_fields();
    bus.imm_ready_i   = 1'b1;
    bus.instr_valid_i = 1'b1;
    bus.instr_i       = 32'h0040006F;
    tick();
    checks++;
    if (bus.immctrl_o !== 5'b10000) begin fails++; $display("FAIL jal_immctrl: got %05b expected 10000", bus.immctrl_o); end
    checks++;
    if (bus.jimm_o !== 20'h00002) begin fails++; $display("FAIL jal_jimm: got %05h expected 00002", bus.jimm_o); end
    bus.instr_i = 32'hFE000EE3;
    tick();
    checks++;
    if (bus.immctrl_o !== 5'b00100) begin fails++; $display("FAIL beq_immctrl: got %05b expected 00100", bus.immctrl_o); end
    checks++;
    if (bus.bimm_o !== 12'hFFE) begin fails++; $display("FAIL beq_bimm: got %03h expected ffe", bus.bimm_o); end
    bus.instr_i = 32'h00112623;
    tick();
    checks++;
    if (bus.immctrl_o !== 5'b00010 || bus.simm_o !== 12'h00C) begin
      fails++; $display("FAIL sw_decode: got ctrl=%05b simm=%03h expected ctrl=00010 simm=00c", bus.immctrl_o, bus.simm_o);
    end
    bus.instr_i = 32'h123450B7;
    tick();
    checks++;
    if (bus.immctrl_o !== 5'b01000 || bus.uimm_o !== 20'h12345) begin
      fails++; $display("FAIL lui_decode: got ctrl=%05b uimm=%05h expected ctrl=01000 uimm=12345", bus.immctrl_o, bus.uimm_o);
    end
    bus.instr_i = 32'h00000033;
    tick();
    bus.instr_valid_i = 1'b0;
    checks++;
    if (bus.imm_valid_o !== 1'b1 || bus.immctrl_o !== 5'b00000 || bus.imm_illegal_o !== 1'b0) begin
      fails++; $display("FAIL add_decode: got v=%0b ctrl=%05b ill=%0b expected v=1 ctrl=00000 ill=0",
                        bus.imm_valid_o, bus.immctrl_o, bus.imm_illegal_o);
    end
    tick();
    checks++;
    if (bus.imm_valid_o !== 1'b0) begin fails++; $display("FAIL fields_drain: got %0b expected 0", bus.imm_valid_o); end
  endtask

  task automatic test_back_to_back();
    bus.imm_ready_i   = 1'b0;
    bus.instr_valid_i = 1'b1;
    bus.instr_i       = 32'h00100093;
    tick();
    checks++;
    if (bus.instr_ready_o !== 1'b1 || bus.iimm_o !== 12'h001) begin
      fails++; $display("FAIL b2b_first: got rdy=%0b iimm=%03h expected rdy=1 iimm=001", bus.instr_ready_o, bus.iimm_o);
    end
    bus.instr_i = 32'h00200113;
    tick();
    checks++;
    if (bus.instr_ready_o !== 1'b0) begin fails++; $display("FAIL b2b_stall: got %0b expected 0", bus.instr_ready_o); end
    bus.instr_i = 32'h00300193;
    tick();
    checks++;
    if (bus.instr_ready_o !== 1'b0 || bus.iimm_o !== 12'h001) begin
      fails++; $display("FAIL b2b_hold: got rdy=%0b iimm=%03h expected rdy=0 iimm=001", bus.instr_ready_o, bus.iimm_o);
    end
    bus.imm_ready_i = 1'b1;
    tick();
    checks++;
    if (bus.iimm_o !== 12'h002 || bus.instr_ready_o !== 1'b1) begin
      fails++; $display("FAIL b2b_second: got iimm=%03h rdy=%0b expected iimm=002 rdy=1", bus.iimm_o, bus.instr_ready_o);
    end
    tick();
    bus.instr_valid_i = 1'b0;
    checks++;
    if (bus.iimm_o !== 12'h003 || bus.imm_valid_o !== 1'b1) begin
      fails++; $display("FAIL b2b_third: got iimm=%03h v=%0b expected iimm=003 v=1", bus.iimm_o, bus.imm_valid_o);
    end
    tick();
    checks++;
    if (bus.imm_valid_o !== 1'b0) begin fails++; $display("FAIL b2b_empty: got %0b expected 0", bus.imm_valid_o); end
  endtask

  task automatic test_flush();
    bus.imm_ready_i   = 1'b0;
    bus.instr_valid_i = 1'b1;
    bus.instr_i       = 32'h00100093;
    tick();
    bus.instr_i = 32'h00200113;
    tick();
    bus.instr_i = 32'h00400213;
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    bus.instr_valid_i = 1'b0;
    checks++;
    if (bus.imm_valid_o !== 1'b0 || bus.instr_ready_o !== 1'b1) begin
      fails++; $display("FAIL flush_state: got v=%0b rdy=%0b expected v=0 rdy=1", bus.imm_valid_o, bus.instr_ready_o);
    end
    checks++;
    if (bus.immctrl_o !== 5'b00000 || bus.iimm_o !== 12'h000) begin
      fails++; $display("FAIL flush_zero: got ctrl=%05b iimm=%03h expected 00000/000", bus.immctrl_o, bus.iimm_o);
    end
    bus.imm_ready_i = 1'b1;
    tick();
    checks++;
    if (bus.imm_valid_o !== 1'b0) begin fails++; $display("FAIL flush_drop: got %0b expected 0", bus.imm_valid_o); end
  endtask

  task automatic test_reset_mid();
    bus.imm_ready_i   = 1'b0;
    bus.instr_valid_i = 1'b1;
    bus.instr_i       = 32'h0040006F;
    tick();
    bus.instr_i = 32'hFE000EE3;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.instr_valid_i = 1'b0;
    checks++;
    if (bus.imm_valid_o !== 1'b0 || bus.instr_ready_o !== 1'b1 || bus.jimm_o !== 20'h0) begin
      fails++; $display("FAIL midreset: got v=%0b rdy=%0b jimm=%05h expected 0/1/00000",
                        bus.imm_valid_o, bus.instr_ready_o, bus.jimm_o);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] exp_stat;
    bus.imm_ready_i   = 1'b1;
    bus.instr_valid_i = 1'b1;
    bus.instr_i       = 32'h0000007F;
    tick();
    bus.instr_valid_i = 1'b0;
    checks++;
    if (bus.imm_valid_o !== 1'b1 || bus.immctrl_o !== 5'b00000 || bus.imm_illegal_o !== 1'b1) begin
      fails++; $display("FAIL illegal_decode: got v=%0b ctrl=%05b ill=%0b expected v=1 ctrl=00000 ill=1",
                        bus.imm_valid_o, bus.immctrl_o, bus.imm_illegal_o);
    end
    tick();
`ifdef IMM_CTRL_STATS_EN
    exp_stat = 32'd1;
`else
    exp_stat = 32'd0;
`endif
    bus.stat_sel_i = 3'd5;
    #1;
    checks++;
    if (bus.stat_o !== exp_stat) begin fails++; $display("FAIL stat_illegal: got %0d expected %0d", bus.stat_o, exp_stat); end
    bus.stat_sel_i = 3'd6;
    #1;
    checks++;
    if (bus.stat_o !== 32'd0) begin fails++; $display("FAIL stat_sel6: got %0d expected 0", bus.stat_o); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_addi();
    test_fields();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
